// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one memory bus between NUM_MASTERS requesters.
// A grant is held for a whole transaction and ends on slave completion,
// master abort or bus timeout. There is always one IDLE cycle between grants.
//
// Handshake: a master requests by raising exactly one of m_ren/m_wen and holds
// addr/wdata/wmask/ren/wen stable until it sees its own m_done pulse (or it
// aborts by dropping both enables). The slave completes by pulsing s_done for
// one cycle; m_done/m_rdata follow s_done/s_rdata combinationally.
module bus_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [32*NUM_MASTERS-1:0]  m_addr,
  input  logic [32*NUM_MASTERS-1:0]  m_wdata,
  input  logic [4*NUM_MASTERS-1:0]   m_wmask,
  input  logic [NUM_MASTERS-1:0]     m_wen,
  input  logic [NUM_MASTERS-1:0]     m_ren,
  output logic [31:0]                m_rdata,
  output logic [NUM_MASTERS-1:0]     m_done,
  output logic [NUM_MASTERS-1:0]     m_err,
  output logic [31:0]                s_addr,
  output logic [31:0]                s_wdata,
  output logic [3:0]                 s_wmask,
  output logic                       s_wen,
  output logic                       s_ren,
  input  logic [31:0]                s_rdata,
  input  logic                       s_done,
  output logic [NUM_MASTERS-1:0]     grant,
  output logic                       busy,
  output logic                       state_dbg
);

  localparam int IW = $clog2(NUM_MASTERS);
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IW-1:0]          last_q, last_d;
  logic [TW-1:0]          tmo_q, tmo_d;

  logic [NUM_MASTERS-1:0] req;
  logic                   pick_valid;
  logic [IW-1:0]          pick_idx;

  logic [31:0] addr_v  [NUM_MASTERS];
  logic [31:0] wdata_v [NUM_MASTERS];
  logic [3:0]  wmask_v [NUM_MASTERS];

  logic g_ren, g_wen, abort, tmo_hit;

  // Unpack the flat per-master buses into indexable arrays.
  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_unpack
    assign addr_v[i]  = m_addr[32*i+31 -: 32];
    assign wdata_v[i] = m_wdata[32*i+31 -: 32];
    assign wmask_v[i] = m_wmask[4*i+3 -: 4];
  end

  assign req       = m_ren | m_wen;
  assign grant     = grant_q;
  assign busy      = (state_q == BUSY);
  assign state_dbg = (state_q == BUSY);

  // Round-robin pick: first requester after last. Scanning from the farthest
  // candidate to the nearest lets the nearest one overwrite the result.
  always_comb begin : arbitrate
    int cand;
    logic [IW-1:0] cand_idx;
    pick_valid = 1'b0;
    pick_idx   = last_q;
    cand       = 0;
    cand_idx   = '0;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      cand     = (int'(last_q) + k) % NUM_MASTERS;
      cand_idx = IW'(cand);
      if (req[cand_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  // Transaction-ending conditions for the currently granted master (last_q).
  always_comb begin
    g_ren   = m_ren[last_q];
    g_wen   = m_wen[last_q];
    abort   = !(g_ren || g_wen);
    tmo_hit = (TIMEOUT_CYCLES != 0) && (tmo_q == TMO_LAST) && !s_done;
  end

  // Next-state logic and bus steering; all slave-side outputs are zero in IDLE.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    tmo_d   = tmo_q;
    s_addr  = '0;
    s_wdata = '0;
    s_wmask = '0;
    s_wen   = 1'b0;
    s_ren   = 1'b0;
    m_done  = '0;
    m_err   = '0;
    m_rdata = s_rdata;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d          = BUSY;
          grant_d          = '0;
          grant_d[pick_idx] = 1'b1;
          last_d           = pick_idx;
          tmo_d            = '0;
        end
      end
      BUSY: begin
        s_addr  = addr_v[last_q];
        s_wdata = wdata_v[last_q];
        s_wmask = wmask_v[last_q];
        s_ren   = g_ren && !tmo_hit;
        s_wen   = g_wen && !tmo_hit;
        // An aborting master gets no completion, even if s_done coincides.
        if (!abort && s_done) begin
          m_done[last_q] = 1'b1;
        end else if (!abort && tmo_hit) begin
          m_done[last_q] = 1'b1;
          m_err[last_q]  = 1'b1;
          m_rdata        = '0;
        end
        if (s_done || abort || tmo_hit) begin
          state_d = IDLE;
          grant_d = '0;
        end else if (tmo_q != {TW{1'b1}}) begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State registers; reset leaves last at the top index so master 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IW'(NUM_MASTERS - 1);
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      tmo_q   <= tmo_d;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: single read, contention, store forwarding,
// timeout (with and without a coincident s_done), abort and mid-BUSY reset.
module tb_bus_arbiter;

  localparam int N   = 2;
  localparam int TMO = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [32*N-1:0] m_addr;
  logic [32*N-1:0] m_wdata;
  logic [4*N-1:0]  m_wmask;
  logic [N-1:0]    m_wen;
  logic [N-1:0]    m_ren;
  logic [31:0]     m_rdata;
  logic [N-1:0]    m_done;
  logic [N-1:0]    m_err;
  logic [31:0]     s_addr;
  logic [31:0]     s_wdata;
  logic [3:0]      s_wmask;
  logic            s_wen;
  logic            s_ren;
  logic [31:0]     s_rdata;
  logic            s_done;
  logic [N-1:0]    grant;
  logic            busy;
  logic            state_dbg;

  int n_checks = 0;
  int n_err    = 0;

  logic [N-1:0] exp_q[$];
  logic [N-1:0] exp_g;

  // Clock and DUT
  always #5 clk = ~clk;

  bus_arbiter #(.NUM_MASTERS(N), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_wmask(m_wmask),
    .m_wen(m_wen), .m_ren(m_ren),
    .m_rdata(m_rdata), .m_done(m_done), .m_err(m_err),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_wmask(s_wmask),
    .s_wen(s_wen), .s_ren(s_ren),
    .s_rdata(s_rdata), .s_done(s_done),
    .grant(grant), .busy(busy), .state_dbg(state_dbg)
  );

  // Advance to just after the next rising edge; inputs for the new cycle follow.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_master(input int i, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] wm, input logic ren, input logic wen);
    m_addr[32*i +: 32] = a;
    m_wdata[32*i +: 32] = d;
    m_wmask[4*i +: 4]  = wm;
    m_ren[i]           = ren;
    m_wen[i]           = wen;
  endtask

  initial begin
    rst = 1'b1;
    m_addr = '0; m_wdata = '0; m_wmask = '0; m_wen = '0; m_ren = '0;
    s_rdata = '0; s_done = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #3;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_sren", 32'(s_ren), 32'h0);
    chk("rst_swen", 32'(s_wen), 32'h0);
    chk("rst_mdone", 32'(m_done), 32'h0);
    rst = 1'b0;

    // Single read: cycle 0 is this IDLE cycle
    set_master(0, 32'h100, 32'h0, 4'h0, 1'b1, 1'b0);
    #1;
    chk("rd_c0_sren", 32'(s_ren), 32'h0);
    tick(); #1;
    chk("rd_c1_sren", 32'(s_ren), 32'h1);
    chk("rd_c1_saddr", s_addr, 32'h100);
    chk("rd_c1_grant", 32'(grant), 32'h1);
    tick(); #1;
    chk("rd_c2_mdone", 32'(m_done), 32'h0);
    tick(); #1;
    chk("rd_c3_mdone", 32'(m_done), 32'h0);
    tick();
    s_done = 1'b1; s_rdata = 32'hCAFEF00D;
    #1;
    chk("rd_c4_mdone", 32'(m_done), 32'h1);
    chk("rd_c4_rdata", m_rdata, 32'hCAFEF00D);
    chk("rd_c4_merr", 32'(m_err), 32'h0);
    tick();
    s_done = 1'b0;
    set_master(0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    #1;
    chk("rd_c5_grant", 32'(grant), 32'h0);
    chk("rd_c5_busy", 32'(busy), 32'h0);
    chk("rd_c5_mdone", 32'(m_done), 32'h0);

    // Contention: master 0 was granted last, so master 1 goes first
    set_master(0, 32'h1000, 32'h0, 4'h0, 1'b1, 1'b0);
    set_master(1, 32'h2000, 32'h0, 4'h0, 1'b1, 1'b0);
    s_done = 1'b1;
    exp_q.push_back(2'b10);
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b10);
    exp_q.push_back(2'b01);
    for (int i = 0; i < 4; i++) begin
      tick(); #1;
      exp_g = exp_q.pop_front();
      chk("ct_grant", 32'(grant), 32'(exp_g));
      chk("ct_mdone", 32'(m_done), 32'(exp_g));
      chk("ct_saddr", s_addr, (exp_g == 2'b01) ? 32'h1000 : 32'h2000);
      tick(); #1;
      chk("ct_gap_grant", 32'(grant), 32'h0);
      chk("ct_gap_mdone", 32'(m_done), 32'h0);
    end
    set_master(0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    set_master(1, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    s_done = 1'b0;

    // Store forwarding from master 1
    tick();
    set_master(1, 32'h203, 32'h12345678, 4'b1000, 1'b0, 1'b1);
    #1;
    chk("st_idle_swen", 32'(s_wen), 32'h0);
    tick(); #1;
    chk("st_grant", 32'(grant), 32'h2);
    chk("st_swen", 32'(s_wen), 32'h1);
    chk("st_sren", 32'(s_ren), 32'h0);
    chk("st_saddr", s_addr, 32'h203);
    chk("st_swdata", s_wdata, 32'h12345678);
    chk("st_swmask", 32'(s_wmask), 32'h8);
    tick();
    s_done = 1'b1;
    #1;
    chk("st_mdone", 32'(m_done), 32'h2);
    chk("st_merr", 32'(m_err), 32'h0);
    tick();
    s_done = 1'b0;
    #1;
    chk("st_after_swen", 32'(s_wen), 32'h0);
    chk("st_after_saddr", s_addr, 32'h0);
    chk("st_after_grant", 32'(grant), 32'h0);
    set_master(1, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);

    // Timeout: no s_done for TMO BUSY cycles
    set_master(0, 32'h40, 32'h0, 4'h0, 1'b1, 1'b0);
    tick(); #1;
    chk("to_b1_grant", 32'(grant), 32'h1);
    chk("to_b1_sren", 32'(s_ren), 32'h1);
    tick(); #1;
    chk("to_b2_mdone", 32'(m_done), 32'h0);
    tick(); #1;
    chk("to_b3_mdone", 32'(m_done), 32'h0);
    tick();
    s_rdata = 32'hDEADBEEF;
    #1;
    chk("to_b4_mdone", 32'(m_done), 32'h1);
    chk("to_b4_merr", 32'(m_err), 32'h1);
    chk("to_b4_sren", 32'(s_ren), 32'h0);
    chk("to_b4_rdata", m_rdata, 32'h0);
    tick(); #1;
    chk("to_idle_busy", 32'(busy), 32'h0);
    chk("to_idle_merr", 32'(m_err), 32'h0);

    // Repeat with s_done on the 4th BUSY cycle: completion beats the timeout
    tick(); #1;
    chk("tr_b1_grant", 32'(grant), 32'h1);
    tick(); #1;
    tick(); #1;
    chk("tr_b3_merr", 32'(m_err), 32'h0);
    tick();
    s_done = 1'b1;
    #1;
    chk("tr_b4_mdone", 32'(m_done), 32'h1);
    chk("tr_b4_merr", 32'(m_err), 32'h0);
    chk("tr_b4_sren", 32'(s_ren), 32'h1);
    chk("tr_b4_rdata", m_rdata, 32'hDEADBEEF);
    tick();
    s_done = 1'b0;
    set_master(0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    #1;
    chk("tr_idle_busy", 32'(busy), 32'h0);

    // Abort: master 0 drops ren during BUSY
    set_master(0, 32'h80, 32'h0, 4'h0, 1'b1, 1'b0);
    tick(); #1;
    chk("ab_b1_sren", 32'(s_ren), 32'h1);
    tick();
    set_master(0, 32'h80, 32'h0, 4'h0, 1'b0, 1'b0);
    #1;
    chk("ab_sren_drop", 32'(s_ren), 32'h0);
    chk("ab_mdone", 32'(m_done), 32'h0);
    chk("ab_still_busy", 32'(busy), 32'h1);
    tick(); #1;
    chk("ab_idle_busy", 32'(busy), 32'h0);
    chk("ab_idle_grant", 32'(grant), 32'h0);

    // Reset mid-BUSY while master 1 holds the bus and master 0 waits
    set_master(1, 32'h300, 32'h0, 4'h0, 1'b1, 1'b0);
    tick(); #1;
    chk("rb_grant1", 32'(grant), 32'h2);
    chk("rb_sren", 32'(s_ren), 32'h1);
    set_master(0, 32'h500, 32'h0, 4'h0, 1'b1, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    chk("rb_async_sren", 32'(s_ren), 32'h0);
    chk("rb_async_saddr", s_addr, 32'h0);
    chk("rb_async_grant", 32'(grant), 32'h0);
    chk("rb_async_busy", 32'(busy), 32'h0);
    chk("rb_async_mdone", 32'(m_done), 32'h0);
    tick(); #1;
    chk("rb_held_grant", 32'(grant), 32'h0);
    rst = 1'b0;
    tick(); #1;
    chk("rb_first_grant", 32'(grant), 32'h1);
    chk("rb_first_saddr", s_addr, 32'h500);
    s_done = 1'b1;
    #1;
    chk("rb_first_mdone", 32'(m_done), 32'h1);
    tick();
    s_done = 1'b0;
    set_master(0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    set_master(1, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    #1;
    chk("rb_end_busy", 32'(busy), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
